calc1_port_sequencer: RTL and testbench

- Shares one calc1 requester port (4-bit cmd, 32-bit data, 2-bit resp) between NUM_REQ independent clients.
- Each client presents a complete transaction (cmd, op1, op2) with a valid/ready handshake. The block round-robin arbitrates, drives the calc1 two-cycle request protocol, waits for the response with a timeout, and returns resp/data to the granted client.
- Sits between bench/system clients and one calc1 port pair (e.g. req1_cmd_in/req1_data_in, out_resp1/out_data1).

---
 rtl/calc1_pkg.sv | 31 +++
 rtl/calc1_rr_arbiter.sv | 42 ++++
 rtl/calc1_port_sequencer.sv | 167 ++++++++++++++++
 tb/tb_calc1_port_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// calc1_pkg
//   Shared definitions for the calc1 port sequencer:
//   - calc1 command codes
//   - response codes
//   - sequencer FSM state encoding
package calc1_pkg;

   // calc1 command codes. Any other code is forwarded untouched and the
   // calc answers it with RESP_ERR.
   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   // calc1 response codes
   localparam logic [1:0] RESP_NONE     = 2'd0;
   localparam logic [1:0] RESP_OK       = 2'd1;
   localparam logic [1:0] RESP_ERR      = 2'd2;
   localparam logic [1:0] RESP_INTERNAL = 2'd3;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // arbitrate and accept a client transaction
      ST_CMD  = 3'd1,   // calc sees cmd + op1
      ST_OP2  = 3'd2,   // calc sees op2
      ST_WAIT = 3'd3,   // wait for a calc response or time out
      ST_RESP = 3'd4    // one-cycle response strobe to the owning client
   } state_t;

endpackage

// File: rtl/calc1_rr_arbiter.sv
// calc1_rr_arbiter
//   Combinational round-robin grant. The search starts at ptr and wraps
//   modulo NUM_REQ; the first asserted req_valid wins. The pointer register
//   itself lives in the parent.
// Ports:
//   req_valid  in   per-client request valid
//   ptr        in   client index with highest priority this cycle
//   grant      out  one-hot grant (all zero when nothing is valid)
//   grant_idx  out  index of the granted client
//   grant_any  out  some client is granted
module calc1_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               grant_any
);

   logic [IW-1:0] j;

   // Walk the offsets from farthest to nearest so the nearest valid client
   // (lowest offset from ptr) is the last one written and therefore wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[j]) begin
            grant     = '0;
            grant[j]  = 1'b1;
            grant_idx = j;
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc1_port_sequencer.sv
// calc1_port_sequencer
//   Shares one calc1 requester port between NUM_REQ clients. A client's
//   (cmd, op1, op2) is accepted by round-robin, driven onto the calc as the
//   two-cycle request (cmd+op1, then op2), and the calc response (or a
//   timeout/local-reject response) is returned on a shared bus with a
//   one-hot strobe. One transaction is outstanding at a time.
// Ports:
//   c_clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready          per-client handshake (ready is one-hot)
//   req_cmd/req_op1/req_op2      packed client fields, client i at [i*W +: W]
//   rsp_valid                    one-hot single-cycle response strobe
//   rsp_resp/rsp_data            shared response bus, valid with rsp_valid
//   calc_cmd_out/calc_data_out   to calc1 reqN_cmd_in / reqN_data_in
//   calc_resp_in/calc_data_in    from calc1 out_respN / out_dataN
module calc1_port_sequencer
   import calc1_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
   input  logic [NUM_REQ*DATA_W-1:0] req_op1,
   input  logic [NUM_REQ*DATA_W-1:0] req_op2,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [1:0]                rsp_resp,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [CMD_W-1:0]          calc_cmd_out,
   output logic [DATA_W-1:0]         calc_data_out,
   input  logic [1:0]                calc_resp_in,
   input  logic [DATA_W-1:0]         calc_data_in
);

   localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Per-client views of the packed request buses
   logic [NUM_REQ-1:0][CMD_W-1:0]  cmd_vec;
   logic [NUM_REQ-1:0][DATA_W-1:0] op1_vec;
   logic [NUM_REQ-1:0][DATA_W-1:0] op2_vec;

   assign cmd_vec = req_cmd;
   assign op1_vec = req_op1;
   assign op2_vec = req_op2;

   state_t              state;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       cur_id;
   logic [DATA_W-1:0]   cur_op2;
   logic [CNT_W-1:0]    wait_cnt;

   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       grant_idx;
   logic                grant_any;
   logic [IW-1:0]       ptr_next;
   logic [NUM_REQ-1:0]  id_onehot;

   calc1_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_arb (
      .req_valid (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Grants are only honoured while idle; the arbiter runs regardless.
   assign req_ready = (state == ST_IDLE) ? grant : '0;

   // Pointer moves to the client just after the winner
   assign ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      id_onehot         = '0;
      id_onehot[cur_id] = 1'b1;
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         cur_id        <= '0;
         cur_op2       <= '0;
         wait_cnt      <= '0;
         rsp_valid     <= '0;
         rsp_resp      <= '0;
         rsp_data      <= '0;
         calc_cmd_out  <= '0;
         calc_data_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= '0;
               rsp_resp  <= '0;
               rsp_data  <= '0;
               if (grant_any) begin
                  cur_id  <= grant_idx;
                  rr_ptr  <= ptr_next;
                  cur_op2 <= op2_vec[grant_idx];
                  if (cmd_vec[grant_idx] == CMD_W'(CMD_NOP)) begin
                     // NOP never reaches the calc: answer it locally next cycle
                     rsp_valid <= grant;
                     rsp_resp  <= RESP_ERR;
                     rsp_data  <= '0;
                     state     <= ST_RESP;
                  end else begin
                     // Outputs are registered, so the first request beat is
                     // loaded here to appear during the CMD cycle.
                     calc_cmd_out  <= cmd_vec[grant_idx];
                     calc_data_out <= op1_vec[grant_idx];
                     state         <= ST_CMD;
                  end
               end
            end

            ST_CMD: begin
               calc_cmd_out  <= '0;
               calc_data_out <= cur_op2;
               state         <= ST_OP2;
            end

            ST_OP2: begin
               calc_data_out <= '0;
               wait_cnt      <= '0;
               state         <= ST_WAIT;
            end

            ST_WAIT: begin
               if (calc_resp_in != RESP_NONE) begin
                  rsp_valid <= id_onehot;
                  rsp_resp  <= calc_resp_in;
                  rsp_data  <= calc_data_in;
                  state     <= ST_RESP;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // TIMEOUT silent WAIT cycles: give up with an internal error.
                  // The counter parks at TIMEOUT until the next OP2 clears it.
                  wait_cnt  <= CNT_W'(TIMEOUT);
                  rsp_valid <= id_onehot;
                  rsp_resp  <= RESP_INTERNAL;
                  rsp_data  <= '0;
                  state     <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               // Strobe lasts one cycle; no grant is made in this cycle
               rsp_valid <= '0;
               rsp_resp  <= '0;
               rsp_data  <= '0;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc1_port_sequencer.sv
// tb_calc1_port_sequencer
//   Directed bench for calc1_port_sequencer. The bench plays both the
//   clients and the calc1 port, with hand-computed responses.
module tb_calc1_port_sequencer;
   import calc1_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int CMD_W   = 4;
   localparam int TIMEOUT = 15;

   logic                      c_clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*CMD_W-1:0]  req_cmd;
   logic [NUM_REQ*DATA_W-1:0] req_op1;
   logic [NUM_REQ*DATA_W-1:0] req_op2;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [1:0]                rsp_resp;
   logic [DATA_W-1:0]         rsp_data;
   logic [CMD_W-1:0]          calc_cmd_out;
   logic [DATA_W-1:0]         calc_data_out;
   logic [1:0]                calc_resp_in;
   logic [DATA_W-1:0]         calc_data_in;

   int checks = 0;
   int errors = 0;

   calc1_port_sequencer #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .CMD_W   (CMD_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_cmd       (req_cmd),
      .req_op1       (req_op1),
      .req_op2       (req_op2),
      .rsp_valid     (rsp_valid),
      .rsp_resp      (rsp_resp),
      .rsp_data      (rsp_data),
      .calc_cmd_out  (calc_cmd_out),
      .calc_data_out (calc_data_out),
      .calc_resp_in  (calc_resp_in),
      .calc_data_in  (calc_data_in)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   // Absolute time bound in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one transaction for client id starting in an IDLE cycle.
   // k    : WAIT cycle in which the calc answers (-1 = never answers)
   // noise: drive a bogus calc response during CMD/OP2, which must be ignored
   task automatic do_txn(input string nm, input int id, input logic [3:0] cmd,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input int k, input logic [1:0] mresp, input logic [31:0] mdata,
                         input bit noise, input logic [1:0] eresp, input logic [31:0] edata);
      logic [3:0] oh;
      int n;
      oh = 4'b0001 << id;
      req_cmd[id*CMD_W +: CMD_W]   = cmd;
      req_op1[id*DATA_W +: DATA_W] = op1;
      req_op2[id*DATA_W +: DATA_W] = op2;
      req_valid[id] = 1'b1;
      #1;
      chk({nm, " ready"}, 64'(req_ready), 64'(oh));
      step();
      req_valid[id] = 1'b0;
      if (cmd == CMD_NOP) begin
         chk({nm, " rej rsp_valid"}, 64'(rsp_valid), 64'(oh));
         chk({nm, " rej resp"}, 64'(rsp_resp), 64'(RESP_ERR));
         chk({nm, " rej data"}, 64'(rsp_data), 64'h0);
         chk({nm, " rej calc_cmd"}, 64'(calc_cmd_out), 64'h0);
         chk({nm, " rej ready"}, 64'(req_ready), 64'h0);
      end else begin
         if (noise) begin
            calc_resp_in = RESP_OK;
            calc_data_in = 32'hDEAD_BEEF;
         end
         chk({nm, " cmd beat cmd"}, 64'(calc_cmd_out), 64'(cmd));
         chk({nm, " cmd beat data"}, 64'(calc_data_out), 64'(op1));
         chk({nm, " cmd beat ready"}, 64'(req_ready), 64'h0);
         step();
         chk({nm, " op2 beat cmd"}, 64'(calc_cmd_out), 64'h0);
         chk({nm, " op2 beat data"}, 64'(calc_data_out), 64'(op2));
         step();
         calc_resp_in = RESP_NONE;
         calc_data_in = '0;
         n = (k < 0) ? TIMEOUT : k;
         for (int w = 0; w < n; w++) begin
            chk({nm, " wait rsp_valid"}, 64'(rsp_valid), 64'h0);
            if (w == 0) begin
               chk({nm, " wait calc_cmd"}, 64'(calc_cmd_out), 64'h0);
               chk({nm, " wait calc_data"}, 64'(calc_data_out), 64'h0);
            end
            step();
         end
         if (k >= 0) begin
            calc_resp_in = mresp;
            calc_data_in = mdata;
            step();
            calc_resp_in = RESP_NONE;
            calc_data_in = '0;
         end
         chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(oh));
         chk({nm, " rsp_resp"}, 64'(rsp_resp), 64'(eresp));
         chk({nm, " rsp_data"}, 64'(rsp_data), 64'(edata));
         chk({nm, " resp ready"}, 64'(req_ready), 64'h0);
      end
      step();
      chk({nm, " idle rsp_valid"}, 64'(rsp_valid), 64'h0);
      chk({nm, " idle rsp_resp"}, 64'(rsp_resp), 64'h0);
      chk({nm, " idle rsp_data"}, 64'(rsp_data), 64'h0);
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = '0;
      req_cmd      = '0;
      req_op1      = '0;
      req_op2      = '0;
      calc_resp_in = '0;
      calc_data_in = '0;
      step();
      step();
      chk("reset req_ready", 64'(req_ready), 64'h0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset rsp_resp", 64'(rsp_resp), 64'h0);
      chk("reset rsp_data", 64'(rsp_data), 64'h0);
      chk("reset calc_cmd", 64'(calc_cmd_out), 64'h0);
      chk("reset calc_data", 64'(calc_data_out), 64'h0);
      reset = 1'b0;
      step();

      // Client 0 add, calc answers in WAIT cycle 1. Pointer -> 1.
      do_txn("add0", 0, CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, 1,
             RESP_OK, 32'h2000_0000, 1'b0, RESP_OK, 32'h2000_0000);

      // Client 1 NOP: local reject. Pointer -> 2.
      do_txn("nop1", 1, CMD_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 0,
             RESP_NONE, 32'h0, 1'b0, RESP_ERR, 32'h0);

      // Client 2 overflowing add, calc reports error which is forwarded.
      // Bogus response during CMD/OP2 must not end the transaction. Pointer -> 3.
      do_txn("ovf2", 2, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0,
             RESP_ERR, 32'h0, 1'b1, RESP_ERR, 32'h0);

      // Client 3, calc never answers: internal error after 15 WAIT cycles. Pointer -> 0.
      do_txn("tmo3", 3, CMD_SUB, 32'h0000_0010, 32'h0000_0003, -1,
             RESP_NONE, 32'h0, 1'b0, RESP_INTERNAL, 32'h0);

      // Clients 0, 1, 3 valid together with pointer at 0: order 0, 1, 3.
      // Client 0 comes back while 1 and 3 are pending and is served after 3.
      req_valid = 4'b1011;
      do_txn("rr0", 0, CMD_SHL, 32'h0000_0003, 32'h0000_0004, 0,
             RESP_OK, 32'h0000_0030, 1'b0, RESP_OK, 32'h0000_0030);
      req_valid[0] = 1'b1;
      do_txn("rr1", 1, CMD_SUB, 32'h0000_0009, 32'h0000_0002, 2,
             RESP_OK, 32'h0000_0007, 1'b0, RESP_OK, 32'h0000_0007);
      do_txn("rr3", 3, CMD_SHR, 32'h0000_0100, 32'h0000_0004, 0,
             RESP_OK, 32'h0000_0010, 1'b0, RESP_OK, 32'h0000_0010);
      do_txn("rr0b", 0, CMD_ADD, 32'h0000_0002, 32'h0000_0003, 3,
             RESP_OK, 32'h0000_0005, 1'b0, RESP_OK, 32'h0000_0005);
      chk("rr drained ready", 64'(req_ready), 64'h0);

      // Reset in WAIT: client 2 accepted (pointer -> 3), reset pulsed mid-wait
      req_cmd[2*CMD_W +: CMD_W]   = CMD_ADD;
      req_op1[2*DATA_W +: DATA_W] = 32'h0000_0005;
      req_op2[2*DATA_W +: DATA_W] = 32'h0000_0006;
      req_valid = 4'b0100;
      #1;
      chk("rst txn ready", 64'(req_ready), 64'h4);
      step();
      req_valid = '0;
      step();
      step();
      step();
      reset        = 1'b1;
      calc_resp_in = RESP_OK;
      calc_data_in = 32'h0000_000B;
      step();
      chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst rsp_resp", 64'(rsp_resp), 64'h0);
      chk("rst calc_cmd", 64'(calc_cmd_out), 64'h0);
      chk("rst calc_data", 64'(calc_data_out), 64'h0);
      reset        = 1'b0;
      calc_resp_in = RESP_NONE;
      calc_data_in = '0;
      step();
      chk("post rst rsp_valid", 64'(rsp_valid), 64'h0);

      // Pointer must be back at 0: with 0 and 3 valid, 0 wins
      req_valid = 4'b1001;
      do_txn("post0", 0, CMD_ADD, 32'h0000_0005, 32'h0000_0006, 0,
             RESP_OK, 32'h0000_000B, 1'b0, RESP_OK, 32'h0000_000B);
      do_txn("post3", 3, CMD_SUB, 32'h0000_0008, 32'h0000_0008, 1,
             RESP_OK, 32'h0000_0000, 1'b0, RESP_OK, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
